// File: rtl/cpu_defs.sv
// Shared CPU definitions: ALU op codes, MIPS opcode/funct constants, the
// decoded issue payload and immediate-extension helpers. Used by the ALU,
// the control unit and the issue stage.
package cpu_defs;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned SHAMT_W  = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_NOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Primary opcodes (instr[31:26])
    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_BNE   = 6'b000101;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_ADDIU = 6'b001001;
    localparam logic [OPC_W-1:0] OPC_SLTI  = 6'b001010;
    localparam logic [OPC_W-1:0] OPC_SLTIU = 6'b001011;
    localparam logic [OPC_W-1:0] OPC_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OPC_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OPC_XORI  = 6'b001110;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [FUNCT_W-1:0] FN_SRL  = 6'b000010;
    localparam logic [FUNCT_W-1:0] FN_SRLV = 6'b000110;
    localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_XOR  = 6'b100110;
    localparam logic [FUNCT_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_SLTU = 6'b101011;

    // Decoded operands handed from issue to EX
    typedef struct packed {
        alu_op_e           op;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic              illegal;
    } issue_t;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    function automatic logic [XLEN-1:0] zext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decode for the ALU issue stage.
// Ports: instr, rs_val, rt_val (in) -> op, a, b, illegal (combinational out).
// Unrecognised encodings fall back to ADD rs,rt with illegal set.
module alu_decode
    import cpu_defs::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output alu_op_e         op,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic            illegal
);

    logic [OPC_W-1:0]   opcode;
    logic [FUNCT_W-1:0] funct;
    logic [SHAMT_W-1:0] shamt;
    logic [IMM_W-1:0]   imm;
    logic               unused_reg_idx;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign shamt  = instr[10:6];
    assign imm    = instr[15:0];

    // Register indices are resolved upstream; operand values arrive directly.
    assign unused_reg_idx = ^instr[25:16];

    // Field decode; defaults double as the illegal-instruction fallback.
    always_comb begin
        op      = ALU_ADD;
        a       = rs_val;
        b       = rt_val;
        illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: op = ALU_ADD;
                    FN_SUB, FN_SUBU: op = ALU_SUB;
                    FN_AND:          op = ALU_AND;
                    FN_OR:           op = ALU_OR;
                    FN_XOR:          op = ALU_XOR;
                    FN_NOR:          op = ALU_NOR;
                    FN_SLT, FN_SLTU: op = ALU_SLT;
                    FN_SRL: begin
                        op = ALU_SRL;
                        a  = rt_val;
                        b  = XLEN'(shamt);
                    end
                    FN_SRLV: begin
                        op = ALU_SRL;
                        a  = rt_val;
                        b  = XLEN'(rs_val[SHAMT_W-1:0]);
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
                op = ALU_ADD;
                b  = sext_imm(imm);
            end
            OPC_SLTI, OPC_SLTIU: begin
                op = ALU_SLT;
                b  = sext_imm(imm);
            end
            OPC_ANDI: begin
                op = ALU_AND;
                b  = zext_imm(imm);
            end
            OPC_ORI: begin
                op = ALU_OR;
                b  = zext_imm(imm);
            end
            OPC_XORI: begin
                op = ALU_XOR;
                b  = zext_imm(imm);
            end
            OPC_BEQ, OPC_BNE: op = ALU_SUB;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction and holds the resulting operands in
// a single valid/ready output register for the EX stage.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/instr/rs_val/rt_val
// from decode; flush kills the held entry; out_valid/out_ready handshake with
// EX carrying registered alu_a, alu_b, alu_op, illegal.
module alu_issue
    import cpu_defs::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     instr,
    input  logic [XLEN-1:0]     rs_val,
    input  logic [XLEN-1:0]     rt_val,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal
);

    issue_t dec;
    issue_t held_q;
    logic   capture;

    alu_decode u_decode (
        .instr   (instr),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .op      (dec.op),
        .a       (dec.a),
        .b       (dec.b),
        .illegal (dec.illegal)
    );

    // Single-entry buffer: free when empty or being drained this cycle.
    assign in_ready = !out_valid | out_ready;
    // Flush wins over any same-cycle transfer; in_ready itself stays ungated.
    assign capture  = in_valid & in_ready & !flush;

    // Valid bit: flush > capture > drain > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only changes on capture, so a flushed entry's operands linger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
        end else if (capture) begin
            held_q <= dec;
        end
    end

    assign alu_a   = held_q.a;
    assign alu_b   = held_q.b;
    assign alu_op  = held_q.op;
    assign illegal = held_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        illegal;

    int n_vec  = 0;
    int n_miss = 0;

    issue_t exp_cur;
    issue_t sb[$];

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic issue_t mk(input alu_op_e op, input logic [31:0] a,
                                  input logic [31:0] b, input logic ill);
        issue_t r;
        r.op = op; r.a = a; r.b = b; r.illegal = ill;
        return r;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] i, input logic [31:0] rs,
                          input logic [31:0] rt, input issue_t e);
        in_valid = v; instr = i; rs_val = rs; rt_val = rt; exp_cur = e;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    // Scoreboard: push on accepted input, pop on EX consumption, drop on flush.
    always @(negedge clk) begin
        issue_t got;
        issue_t exp;
        if (rst_n) begin
            if (out_valid) begin
                if (flush) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                end else if (out_ready) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_miss++;
                        $display("FAIL sb_unexpected: out_valid consumed with no pending entry, a=%h b=%h", alu_a, alu_b);
                    end else begin
                        exp = sb.pop_front();
                        got.op = alu_op_e'(alu_op);
                        got.a = alu_a; got.b = alu_b; got.illegal = illegal;
                        if (got !== exp) begin
                            n_miss++;
                            $display("FAIL sb_payload: got op=%b a=%h b=%h ill=%b, want op=%b a=%h b=%h ill=%b",
                                     got.op, got.a, got.b, got.illegal, exp.op, exp.a, exp.b, exp.illegal);
                        end
                    end
                end
            end
            if (in_valid && in_ready && !flush) sb.push_back(exp_cur);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 32'h0, mk(ALU_AND, 32'h0, 32'h0, 1'b0));
        #3;
        n_vec++;
        if ({out_valid, alu_a, alu_b, alu_op, illegal} !== 68'h0) begin
            n_miss++;
            $display("FAIL reset_outputs: got v=%b a=%h b=%h op=%b ill=%b, want all 0",
                     out_valid, alu_a, alu_b, alu_op, illegal);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        set_in(1'b1, 32'h00221820, 32'd5, 32'd7, mk(ALU_ADD, 32'd5, 32'd7, 1'b0));
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, alu_op, alu_a, alu_b, illegal} !== {1'b1, 3'b010, 32'd5, 32'd7, 1'b0}) begin
            n_miss++;
            $display("FAIL add: got v=%b op=%b a=%h b=%h ill=%b, want v=1 op=010 a=5 b=7 ill=0",
                     out_valid, alu_op, alu_a, alu_b, illegal);
        end
        cycle();
    endtask

    task automatic test_imm();
        out_ready = 1'b1;
        set_in(1'b1, 32'h2021FFFF, 32'd10, 32'd3, mk(ALU_ADD, 32'd10, 32'hFFFFFFFF, 1'b0));
        cycle();
        set_in(1'b1, 32'h3421FFFF, 32'd10, 32'd3, mk(ALU_OR, 32'd10, 32'h0000FFFF, 1'b0));
        @(negedge clk);
        n_vec++;
        if ({out_valid, alu_op, alu_a, alu_b} !== {1'b1, 3'b010, 32'd10, 32'hFFFFFFFF}) begin
            n_miss++;
            $display("FAIL addi_sext: got v=%b op=%b a=%h b=%h, want v=1 op=010 a=a b=ffffffff",
                     out_valid, alu_op, alu_a, alu_b);
        end
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, alu_op, alu_a, alu_b} !== {1'b1, 3'b001, 32'd10, 32'h0000FFFF}) begin
            n_miss++;
            $display("FAIL ori_zext: got v=%b op=%b a=%h b=%h, want v=1 op=001 a=a b=0000ffff",
                     out_valid, alu_op, alu_a, alu_b);
        end
        cycle();
    endtask

    task automatic test_srl();
        out_ready = 1'b1;
        set_in(1'b1, 32'h00011102, 32'h0, 32'h80, mk(ALU_SRL, 32'h80, 32'd4, 1'b0));
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, alu_op, alu_a, alu_b} !== {1'b1, 3'b101, 32'h80, 32'd4}) begin
            n_miss++;
            $display("FAIL srl: got v=%b op=%b a=%h b=%h, want v=1 op=101 a=80 b=4",
                     out_valid, alu_op, alu_a, alu_b);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(1'b1, 32'h00221822, 32'd9, 32'd4, mk(ALU_SUB, 32'd9, 32'd4, 1'b0));
        cycle();
        set_in(1'b1, 32'h00221824, 32'hF0F0, 32'hFF00, mk(ALU_AND, 32'hF0F0, 32'hFF00, 1'b0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            if ({in_ready, out_valid, alu_op, alu_a, alu_b} !== {1'b0, 1'b1, 3'b110, 32'd9, 32'd4}) begin
                n_miss++;
                $display("FAIL hold_%0d: got rdy=%b v=%b op=%b a=%h b=%h, want rdy=0 v=1 op=110 a=9 b=4",
                         k, in_ready, out_valid, alu_op, alu_a, alu_b);
            end
            cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL release_ready: got %b want 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, alu_op, alu_a, alu_b} !== {1'b1, 3'b000, 32'hF0F0, 32'hFF00}) begin
            n_miss++;
            $display("FAIL bp_next_load: got v=%b op=%b a=%h b=%h, want v=1 op=000 a=f0f0 b=ff00",
                     out_valid, alu_op, alu_a, alu_b);
        end
        cycle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(1'b1, 32'h38218000, 32'h11, 32'h0, mk(ALU_XOR, 32'h11, 32'h00008000, 1'b0));
        cycle();
        set_in(1'b1, 32'h30211234, 32'hABCD, 32'h0, mk(ALU_AND, 32'hABCD, 32'h1234, 1'b0));
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, alu_op, alu_a, alu_b} !== {1'b0, 3'b011, 32'h11, 32'h00008000}) begin
            n_miss++;
            $display("FAIL flush: got v=%b op=%b a=%h b=%h, want v=0 op=011 a=11 b=8000",
                     out_valid, alu_op, alu_a, alu_b);
        end
        cycle();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        set_in(1'b1, 32'h3C010001, 32'h1234, 32'h5678, mk(ALU_ADD, 32'h1234, 32'h5678, 1'b1));
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, illegal, alu_op, alu_a, alu_b} !== {1'b1, 1'b1, 3'b010, 32'h1234, 32'h5678}) begin
            n_miss++;
            $display("FAIL lui_illegal: got v=%b ill=%b op=%b a=%h b=%h, want v=1 ill=1 op=010 a=1234 b=5678",
                     out_valid, illegal, alu_op, alu_a, alu_b);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        localparam int N = 19;
        logic [31:0] t_i  [N];
        logic [31:0] t_rs [N];
        logic [31:0] t_rt [N];
        issue_t      t_e  [N];
        int idx = 0;
        int cyc = 0;
        logic acc;
        t_i  = '{32'h00221822, 32'h00221824, 32'h00221827, 32'h0022182A, 32'h00221806,
                 32'h28218000, 32'h38218000, 32'h30211234, 32'h8C21FFFC, 32'hAC210010,
                 32'h10220005, 32'h14220005, 32'h00200008, 32'h00221825, 32'h00221826,
                 32'h00221821, 32'h2421FFFE, 32'h2C210001, 32'h0022182B};
        t_rs = '{32'd9, 32'hF0F0, 32'd1, 32'd3, 32'h25, 32'h77, 32'h11, 32'hABCD, 32'h100,
                 32'h200, 32'd6, 32'd1, 32'h33, 32'd5, 32'hFF, 32'd40, 32'd8, 32'd0, 32'd7};
        t_rt = '{32'd4, 32'hFF00, 32'd2, 32'd8, 32'h1000, 32'h55, 32'h22, 32'h99, 32'h3,
                 32'h4, 32'd6, 32'd2, 32'h44, 32'hA, 32'h0F, 32'd2, 32'd9, 32'd5, 32'd7};
        t_e  = '{mk(ALU_SUB, 32'd9, 32'd4, 1'b0),
                 mk(ALU_AND, 32'hF0F0, 32'hFF00, 1'b0),
                 mk(ALU_NOR, 32'd1, 32'd2, 1'b0),
                 mk(ALU_SLT, 32'd3, 32'd8, 1'b0),
                 mk(ALU_SRL, 32'h1000, 32'd5, 1'b0),
                 mk(ALU_SLT, 32'h77, 32'hFFFF8000, 1'b0),
                 mk(ALU_XOR, 32'h11, 32'h00008000, 1'b0),
                 mk(ALU_AND, 32'hABCD, 32'h00001234, 1'b0),
                 mk(ALU_ADD, 32'h100, 32'hFFFFFFFC, 1'b0),
                 mk(ALU_ADD, 32'h200, 32'h00000010, 1'b0),
                 mk(ALU_SUB, 32'd6, 32'd6, 1'b0),
                 mk(ALU_SUB, 32'd1, 32'd2, 1'b0),
                 mk(ALU_ADD, 32'h33, 32'h44, 1'b1),
                 mk(ALU_OR, 32'd5, 32'hA, 1'b0),
                 mk(ALU_XOR, 32'hFF, 32'h0F, 1'b0),
                 mk(ALU_ADD, 32'd40, 32'd2, 1'b0),
                 mk(ALU_ADD, 32'd8, 32'hFFFFFFFE, 1'b0),
                 mk(ALU_SLT, 32'd0, 32'h00000001, 1'b0),
                 mk(ALU_SLT, 32'd7, 32'd7, 1'b0)};
        out_ready = 1'b1;
        while (idx < N && cyc < 400) begin
            set_in(1'b1, t_i[idx], t_rs[idx], t_rt[idx], t_e[idx]);
            @(negedge clk);
            acc = in_ready;
            cycle();
            out_ready = 1'($urandom_range(0, 1));
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        n_vec++;
        if (idx != N) begin
            n_miss++;
            $display("FAIL b2b_timeout: accepted %0d of %0d vectors", idx, N);
        end
        n_vec++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_drain: pending=%0d out_valid=%b, want 0 and 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'h00221826, 32'hFF, 32'h0F, mk(ALU_XOR, 32'hFF, 32'h0F, 1'b0));
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, alu_a, alu_b, alu_op, illegal} !== 68'h0) begin
            n_miss++;
            $display("FAIL async_reset: got v=%b a=%h b=%h op=%b ill=%b, want all 0",
                     out_valid, alu_a, alu_b, alu_op, illegal);
        end
        sb.delete();
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'h0022182A, 32'd3, 32'd8, mk(ALU_SLT, 32'd3, 32'd8, 1'b0));
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL post_reset_ready: got %b want 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, alu_op, alu_a, alu_b} !== {1'b1, 3'b111, 32'd3, 32'd8}) begin
            n_miss++;
            $display("FAIL post_reset_accept: got v=%b op=%b a=%h b=%h, want v=1 op=111 a=3 b=8",
                     out_valid, alu_op, alu_a, alu_b);
        end
        cycle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_srl();
        test_backpressure();
        test_flush();
        test_illegal();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
